axi_mem_arbiter: RTL and testbench
==================================

# axi_mem_arbiter

Two-to-one AXI4 arbiter sharing the single PS memory slave port (`S_AXI_*` of `system`) between the Rocket `io_mem_axi` master (port 0) and a second on-fabric master (port 1, DMA/debug loader). Read and write paths are arbitrated independently, round-robin. Each path allows one outstanding burst, so response routing needs no ID remapping. It sits in the wrapper between `Top`/the second master and `system`, clocked by the MMCM fabric clock.

## Interface

- `ID_W`, 6, AXI ID width, passed through unchanged.
- `ADDR_W`, 32, address width. The wrapper zero-extends it to 49 bits.
- `DATA_W`, 64, data width. Strobe width is `DATA_W/8`.

- `clock`  in  1  fabric clock.
- `reset`  in  1  synchronous, active-high reset.
- `sN_ar_{valid,bits_id,bits_addr,bits_len,bits_size,bits_burst}`  in  1/ID_W/ADDR_W/8/3/2  read address from master N (N=0,1).
- `sN_ar_ready`  out  1  read address accept to master N.
- `sN_r_{valid,bits_id,bits_data,bits_resp,bits_last}`  out  1/ID_W/DATA_W/2/1  read data to master N.
- `sN_r_ready`  in  1  read data accept from master N.
- `sN_aw_{valid,bits_id,bits_addr,bits_len,bits_size,bits_burst}`  in  as for AR  write address from master N.
- `sN_aw_ready`  out  1  write address accept to master N.
- `sN_w_{valid,bits_data,bits_strb,bits_last}`  in  1/DATA_W/DATA_W/8/1  write data from master N.
- `sN_w_ready`  out  1  write data accept to master N.
- `sN_b_{valid,bits_id,bits_resp}`  out  1/ID_W/2  write response to master N.
- `sN_b_ready`  in  1  write response accept from master N.
- `m_{ar,aw,w,r,b}_*`  mirror  same widths  downstream port to PS `S_AXI_*`.
  - Lock, cache, prot and qos are not carried; the wrapper ties them to 0.
- `o_rd_owner`, `o_wr_owner`  out  1 each  current grant on each path, for debug/LED.

## Operation

- **Read FSM, states R_IDLE → R_ADDR → R_DATA.**
  - R_IDLE: with any `sN_ar_valid` asserted, register the grant and go to R_ADDR.
    - Only one requester valid: grant it.
    - Both valid: grant the port not granted last. The `rd_last` flag resets to 1, so port 0 wins first.
    - Update `rd_last` to the granted port.
  - R_ADDR: `m_ar_*` = granted `sN_ar_*`, `sN_ar_ready` = `m_ar_ready` for the granted port only. On `m_ar_valid & m_ar_ready`, go to R_DATA.
  - R_DATA: `sG_r_*` = `m_r_*`, `m_r_ready` = `sG_r_ready`. On handshake with `m_r_bits_last=1`, return to R_IDLE.
- **Write FSM, states W_IDLE → W_ADDR → W_DATA → W_RESP.** Arbitration is identical, with its own `wr_last` flag.
  - W_ADDR: routes AW.
  - W_DATA: routes W. `sG_w_ready` is 0 before the AW handshake completes. Leaves on a W handshake with `w_last=1`.
  - W_RESP: routes B and returns to W_IDLE on a B handshake.
- The non-granted port always sees `ar_ready`, `aw_ready`, `w_ready`, `r_valid` and `b_valid` at 0.
- `m_*_valid` is 0 in every state except the one routing that channel.
- Read and write paths are fully independent: a read on port 0 and a write on port 1 proceed concurrently.
- IDs, data, len, size and burst pass through unmodified. `len` is not counted; `last` alone terminates the burst.

## Timing

- **Reset values:** both FSMs idle; `rd_last`=`wr_last`=1; every valid and ready output 0; owners 0; payload outputs 0.
- **Arbitration latency:** `sN_ar_valid` rising in cycle 0 → `m_ar_valid`=1 in cycle 1 (one registered grant cycle). The same holds for AW.
- **Handshake paths:** all ready/valid and payload paths through the arbiter are combinational in ADDR/DATA/RESP states, so there are no added beats of latency.
- **Burst turnaround:** R_DATA → R_IDLE on the last beat; the next grant is registered in the following cycle. Back-to-back bursts therefore have a one-idle-cycle gap on `m_ar_valid`.
- **Requester withdrawal:** a requester dropping `ar_valid` after grant is an AXI violation. The FSM stays in R_ADDR and forwards `m_ar_valid`=0.
- **Reset mid-burst:** synchronous `reset` returns both FSMs to idle the next cycle. The in-flight downstream transaction is abandoned; `system` is reset by the same source.
- **Fairness:** a continuously requesting port is granted at most every other burst when both request.

## Test plan

- **Single read:** s0 AR (id=3, addr=0x8000_0000, len=3); downstream returns 4 beats → `m_ar_valid` in cycle 1; s0 receives 4 beats with id=3, last on beat 4; s1 `r_valid` stays 0.
- **Read contention:** s0 and s1 assert AR in the same cycle, repeatedly, 4 times → grants s0, s1, s0, s1; `o_rd_owner` toggles each burst.
- **Concurrent read/write:** s0 read len=7 while s1 writes len=1 (strb=0xFF) → both complete; B resp=0 delivered to s1 only; no cross-routing.
- **Write ordering:** s1 asserts W two cycles before AW → `s1_w_ready`=0 until the AW handshake; data reaches `m_w` intact; W_RESP is held while `s1_b_ready`=0 for 5 cycles.
- **Backpressure:** `m_r_ready` low for random cycles on a len=15 burst → all 16 beats delivered in order, none duplicated.
- **Reset mid-burst:** `reset` asserted after beat 2 of an 8-beat read → next cycle all valid/ready are 0 and owner=0; a fresh s1 request is then granted normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: 2:1 AXI4 arbiter in front of the PS memory slave port.
// Read and write paths are arbitrated independently with round-robin
// priority. Each path carries one burst at a time, so responses go back to
// the registered grant and IDs pass through untouched.
module axi_mem_arbiter #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  // master 0 (Rocket io_mem_axi)
  input  logic                s0_ar_valid,
  output logic                s0_ar_ready,
  input  logic [ID_W-1:0]     s0_ar_bits_id,
  input  logic [ADDR_W-1:0]   s0_ar_bits_addr,
  input  logic [7:0]          s0_ar_bits_len,
  input  logic [2:0]          s0_ar_bits_size,
  input  logic [1:0]          s0_ar_bits_burst,
  output logic                s0_r_valid,
  input  logic                s0_r_ready,
  output logic [ID_W-1:0]     s0_r_bits_id,
  output logic [DATA_W-1:0]   s0_r_bits_data,
  output logic [1:0]          s0_r_bits_resp,
  output logic                s0_r_bits_last,
  input  logic                s0_aw_valid,
  output logic                s0_aw_ready,
  input  logic [ID_W-1:0]     s0_aw_bits_id,
  input  logic [ADDR_W-1:0]   s0_aw_bits_addr,
  input  logic [7:0]          s0_aw_bits_len,
  input  logic [2:0]          s0_aw_bits_size,
  input  logic [1:0]          s0_aw_bits_burst,
  input  logic                s0_w_valid,
  output logic                s0_w_ready,
  input  logic [DATA_W-1:0]   s0_w_bits_data,
  input  logic [DATA_W/8-1:0] s0_w_bits_strb,
  input  logic                s0_w_bits_last,
  output logic                s0_b_valid,
  input  logic                s0_b_ready,
  output logic [ID_W-1:0]     s0_b_bits_id,
  output logic [1:0]          s0_b_bits_resp,
  // master 1 (DMA / debug loader)
  input  logic                s1_ar_valid,
  output logic                s1_ar_ready,
  input  logic [ID_W-1:0]     s1_ar_bits_id,
  input  logic [ADDR_W-1:0]   s1_ar_bits_addr,
  input  logic [7:0]          s1_ar_bits_len,
  input  logic [2:0]          s1_ar_bits_size,
  input  logic [1:0]          s1_ar_bits_burst,
  output logic                s1_r_valid,
  input  logic                s1_r_ready,
  output logic [ID_W-1:0]     s1_r_bits_id,
  output logic [DATA_W-1:0]   s1_r_bits_data,
  output logic [1:0]          s1_r_bits_resp,
  output logic                s1_r_bits_last,
  input  logic                s1_aw_valid,
  output logic                s1_aw_ready,
  input  logic [ID_W-1:0]     s1_aw_bits_id,
  input  logic [ADDR_W-1:0]   s1_aw_bits_addr,
  input  logic [7:0]          s1_aw_bits_len,
  input  logic [2:0]          s1_aw_bits_size,
  input  logic [1:0]          s1_aw_bits_burst,
  input  logic                s1_w_valid,
  output logic                s1_w_ready,
  input  logic [DATA_W-1:0]   s1_w_bits_data,
  input  logic [DATA_W/8-1:0] s1_w_bits_strb,
  input  logic                s1_w_bits_last,
  output logic                s1_b_valid,
  input  logic                s1_b_ready,
  output logic [ID_W-1:0]     s1_b_bits_id,
  output logic [1:0]          s1_b_bits_resp,
  // downstream slave (PS S_AXI)
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ID_W-1:0]     m_ar_bits_id,
  output logic [ADDR_W-1:0]   m_ar_bits_addr,
  output logic [7:0]          m_ar_bits_len,
  output logic [2:0]          m_ar_bits_size,
  output logic [1:0]          m_ar_bits_burst,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [ID_W-1:0]     m_r_bits_id,
  input  logic [DATA_W-1:0]   m_r_bits_data,
  input  logic [1:0]          m_r_bits_resp,
  input  logic                m_r_bits_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ID_W-1:0]     m_aw_bits_id,
  output logic [ADDR_W-1:0]   m_aw_bits_addr,
  output logic [7:0]          m_aw_bits_len,
  output logic [2:0]          m_aw_bits_size,
  output logic [1:0]          m_aw_bits_burst,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_bits_data,
  output logic [DATA_W/8-1:0] m_w_bits_strb,
  output logic                m_w_bits_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_bits_id,
  input  logic [1:0]          m_b_bits_resp,
  // debug
  output logic                o_rd_owner,
  output logic                o_wr_owner
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      rd_gnt_q, rd_gnt_d, rd_last_q, rd_last_d;
  logic      wr_gnt_q, wr_gnt_d, wr_last_q, wr_last_d;
  logic      rd_pick, wr_pick;

  // With both masters requesting, the one not served last wins
  assign rd_pick = (s0_ar_valid & s1_ar_valid) ? ~rd_last_q : s1_ar_valid;
  assign wr_pick = (s0_aw_valid & s1_aw_valid) ? ~wr_last_q : s1_aw_valid;

  assign o_rd_owner = rd_gnt_q;
  assign o_wr_owner = wr_gnt_q;

  // Read FSM next state: grant in idle, advance on AR and last-R handshakes
  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: if (s0_ar_valid | s1_ar_valid) begin
        rd_gnt_d   = rd_pick;
        rd_last_d  = rd_pick;
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (m_ar_valid & m_ar_ready) rd_state_d = R_DATA;
      R_DATA: if (m_r_valid & m_r_ready & m_r_bits_last) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers; rd_last resets to 1 so master 0 wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Write FSM next state: grant in idle, then AW, W until last, then B
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_last_d  = wr_last_q;
    case (wr_state_q)
      W_IDLE: if (s0_aw_valid | s1_aw_valid) begin
        wr_gnt_d   = wr_pick;
        wr_last_d  = wr_pick;
        wr_state_d = W_ADDR;
      end
      W_ADDR: if (m_aw_valid & m_aw_ready) wr_state_d = W_DATA;
      W_DATA: if (m_w_valid & m_w_ready & m_w_bits_last) wr_state_d = W_RESP;
      W_RESP: if (m_b_valid & m_b_ready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_last_q  <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_last_q  <= wr_last_d;
    end
  end

  // AR routing: only in R_ADDR, only between the granted master and downstream
  always_comb begin
    m_ar_valid      = 1'b0;
    m_ar_bits_id    = '0;
    m_ar_bits_addr  = '0;
    m_ar_bits_len   = '0;
    m_ar_bits_size  = '0;
    m_ar_bits_burst = '0;
    s0_ar_ready     = 1'b0;
    s1_ar_ready     = 1'b0;
    if (rd_state_q == R_ADDR) begin
      if (rd_gnt_q) begin
        m_ar_valid      = s1_ar_valid;
        m_ar_bits_id    = s1_ar_bits_id;
        m_ar_bits_addr  = s1_ar_bits_addr;
        m_ar_bits_len   = s1_ar_bits_len;
        m_ar_bits_size  = s1_ar_bits_size;
        m_ar_bits_burst = s1_ar_bits_burst;
        s1_ar_ready     = m_ar_ready;
      end else begin
        m_ar_valid      = s0_ar_valid;
        m_ar_bits_id    = s0_ar_bits_id;
        m_ar_bits_addr  = s0_ar_bits_addr;
        m_ar_bits_len   = s0_ar_bits_len;
        m_ar_bits_size  = s0_ar_bits_size;
        m_ar_bits_burst = s0_ar_bits_burst;
        s0_ar_ready     = m_ar_ready;
      end
    end
  end

  // R routing: downstream beats go to the granted master only in R_DATA
  always_comb begin
    m_r_ready      = 1'b0;
    s0_r_valid     = 1'b0;
    s0_r_bits_id   = '0;
    s0_r_bits_data = '0;
    s0_r_bits_resp = '0;
    s0_r_bits_last = 1'b0;
    s1_r_valid     = 1'b0;
    s1_r_bits_id   = '0;
    s1_r_bits_data = '0;
    s1_r_bits_resp = '0;
    s1_r_bits_last = 1'b0;
    if (rd_state_q == R_DATA) begin
      if (rd_gnt_q) begin
        s1_r_valid     = m_r_valid;
        s1_r_bits_id   = m_r_bits_id;
        s1_r_bits_data = m_r_bits_data;
        s1_r_bits_resp = m_r_bits_resp;
        s1_r_bits_last = m_r_bits_last;
        m_r_ready      = s1_r_ready;
      end else begin
        s0_r_valid     = m_r_valid;
        s0_r_bits_id   = m_r_bits_id;
        s0_r_bits_data = m_r_bits_data;
        s0_r_bits_resp = m_r_bits_resp;
        s0_r_bits_last = m_r_bits_last;
        m_r_ready      = s0_r_ready;
      end
    end
  end

  // AW routing: only in W_ADDR
  always_comb begin
    m_aw_valid      = 1'b0;
    m_aw_bits_id    = '0;
    m_aw_bits_addr  = '0;
    m_aw_bits_len   = '0;
    m_aw_bits_size  = '0;
    m_aw_bits_burst = '0;
    s0_aw_ready     = 1'b0;
    s1_aw_ready     = 1'b0;
    if (wr_state_q == W_ADDR) begin
      if (wr_gnt_q) begin
        m_aw_valid      = s1_aw_valid;
        m_aw_bits_id    = s1_aw_bits_id;
        m_aw_bits_addr  = s1_aw_bits_addr;
        m_aw_bits_len   = s1_aw_bits_len;
        m_aw_bits_size  = s1_aw_bits_size;
        m_aw_bits_burst = s1_aw_bits_burst;
        s1_aw_ready     = m_aw_ready;
      end else begin
        m_aw_valid      = s0_aw_valid;
        m_aw_bits_id    = s0_aw_bits_id;
        m_aw_bits_addr  = s0_aw_bits_addr;
        m_aw_bits_len   = s0_aw_bits_len;
        m_aw_bits_size  = s0_aw_bits_size;
        m_aw_bits_burst = s0_aw_bits_burst;
        s0_aw_ready     = m_aw_ready;
      end
    end
  end

  // W routing: only after the AW handshake, so early W data is held off
  always_comb begin
    m_w_valid     = 1'b0;
    m_w_bits_data = '0;
    m_w_bits_strb = '0;
    m_w_bits_last = 1'b0;
    s0_w_ready    = 1'b0;
    s1_w_ready    = 1'b0;
    if (wr_state_q == W_DATA) begin
      if (wr_gnt_q) begin
        m_w_valid     = s1_w_valid;
        m_w_bits_data = s1_w_bits_data;
        m_w_bits_strb = s1_w_bits_strb;
        m_w_bits_last = s1_w_bits_last;
        s1_w_ready    = m_w_ready;
      end else begin
        m_w_valid     = s0_w_valid;
        m_w_bits_data = s0_w_bits_data;
        m_w_bits_strb = s0_w_bits_strb;
        m_w_bits_last = s0_w_bits_last;
        s0_w_ready    = m_w_ready;
      end
    end
  end

  // B routing: response returns to the granted master only in W_RESP
  always_comb begin
    m_b_ready      = 1'b0;
    s0_b_valid     = 1'b0;
    s0_b_bits_id   = '0;
    s0_b_bits_resp = '0;
    s1_b_valid     = 1'b0;
    s1_b_bits_id   = '0;
    s1_b_bits_resp = '0;
    if (wr_state_q == W_RESP) begin
      if (wr_gnt_q) begin
        s1_b_valid     = m_b_valid;
        s1_b_bits_id   = m_b_bits_id;
        s1_b_bits_resp = m_b_bits_resp;
        m_b_ready      = s1_b_ready;
      end else begin
        s0_b_valid     = m_b_valid;
        s0_b_bits_id   = m_b_bits_id;
        s0_b_bits_resp = m_b_bits_resp;
        m_b_ready      = s0_b_ready;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: randomized scenarios against a burst-level model of
// the arbiter (round-robin winner prediction plus sent/received beat queues).
module tb_axi_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // master-side stimulus and observation, indexed by port
  logic        s_ar_valid [2];
  logic [5:0]  s_ar_id    [2];
  logic [31:0] s_ar_addr  [2];
  logic [7:0]  s_ar_len   [2];
  logic [2:0]  s_ar_size  [2];
  logic [1:0]  s_ar_burst [2];
  wire         s_ar_ready [2];
  wire         s_r_valid  [2];
  wire  [5:0]  s_r_id     [2];
  wire  [63:0] s_r_data   [2];
  wire  [1:0]  s_r_resp   [2];
  wire         s_r_last   [2];
  logic        s_r_ready  [2];
  logic        s_aw_valid [2];
  logic [5:0]  s_aw_id    [2];
  logic [31:0] s_aw_addr  [2];
  logic [7:0]  s_aw_len   [2];
  logic [2:0]  s_aw_size  [2];
  logic [1:0]  s_aw_burst [2];
  wire         s_aw_ready [2];
  logic        s_w_valid  [2];
  logic [63:0] s_w_data   [2];
  logic [7:0]  s_w_strb   [2];
  logic        s_w_last   [2];
  wire         s_w_ready  [2];
  wire         s_b_valid  [2];
  wire  [5:0]  s_b_id     [2];
  wire  [1:0]  s_b_resp   [2];
  logic        s_b_ready  [2];

  // downstream slave side
  wire         m_ar_valid;
  logic        m_ar_ready;
  wire  [5:0]  m_ar_id;
  wire  [31:0] m_ar_addr;
  wire  [7:0]  m_ar_len;
  wire  [2:0]  m_ar_size;
  wire  [1:0]  m_ar_burst;
  logic        m_r_valid;
  wire         m_r_ready;
  logic [5:0]  m_r_id;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  wire         m_aw_valid;
  logic        m_aw_ready;
  wire  [5:0]  m_aw_id;
  wire  [31:0] m_aw_addr;
  wire  [7:0]  m_aw_len;
  wire  [2:0]  m_aw_size;
  wire  [1:0]  m_aw_burst;
  wire         m_w_valid;
  logic        m_w_ready;
  wire  [63:0] m_w_data;
  wire  [7:0]  m_w_strb;
  wire         m_w_last;
  logic        m_b_valid;
  wire         m_b_ready;
  logic [5:0]  m_b_id;
  logic [1:0]  m_b_resp;
  wire         rd_owner;
  wire         wr_owner;

  // model state: port that won the last arbitration on each path
  logic exp_rd_last, exp_wr_last;

  axi_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_ar_valid(s_ar_valid[0]), .s0_ar_ready(s_ar_ready[0]), .s0_ar_bits_id(s_ar_id[0]),
    .s0_ar_bits_addr(s_ar_addr[0]), .s0_ar_bits_len(s_ar_len[0]), .s0_ar_bits_size(s_ar_size[0]),
    .s0_ar_bits_burst(s_ar_burst[0]),
    .s0_r_valid(s_r_valid[0]), .s0_r_ready(s_r_ready[0]), .s0_r_bits_id(s_r_id[0]),
    .s0_r_bits_data(s_r_data[0]), .s0_r_bits_resp(s_r_resp[0]), .s0_r_bits_last(s_r_last[0]),
    .s0_aw_valid(s_aw_valid[0]), .s0_aw_ready(s_aw_ready[0]), .s0_aw_bits_id(s_aw_id[0]),
    .s0_aw_bits_addr(s_aw_addr[0]), .s0_aw_bits_len(s_aw_len[0]), .s0_aw_bits_size(s_aw_size[0]),
    .s0_aw_bits_burst(s_aw_burst[0]),
    .s0_w_valid(s_w_valid[0]), .s0_w_ready(s_w_ready[0]), .s0_w_bits_data(s_w_data[0]),
    .s0_w_bits_strb(s_w_strb[0]), .s0_w_bits_last(s_w_last[0]),
    .s0_b_valid(s_b_valid[0]), .s0_b_ready(s_b_ready[0]), .s0_b_bits_id(s_b_id[0]),
    .s0_b_bits_resp(s_b_resp[0]),
    .s1_ar_valid(s_ar_valid[1]), .s1_ar_ready(s_ar_ready[1]), .s1_ar_bits_id(s_ar_id[1]),
    .s1_ar_bits_addr(s_ar_addr[1]), .s1_ar_bits_len(s_ar_len[1]), .s1_ar_bits_size(s_ar_size[1]),
    .s1_ar_bits_burst(s_ar_burst[1]),
    .s1_r_valid(s_r_valid[1]), .s1_r_ready(s_r_ready[1]), .s1_r_bits_id(s_r_id[1]),
    .s1_r_bits_data(s_r_data[1]), .s1_r_bits_resp(s_r_resp[1]), .s1_r_bits_last(s_r_last[1]),
    .s1_aw_valid(s_aw_valid[1]), .s1_aw_ready(s_aw_ready[1]), .s1_aw_bits_id(s_aw_id[1]),
    .s1_aw_bits_addr(s_aw_addr[1]), .s1_aw_bits_len(s_aw_len[1]), .s1_aw_bits_size(s_aw_size[1]),
    .s1_aw_bits_burst(s_aw_burst[1]),
    .s1_w_valid(s_w_valid[1]), .s1_w_ready(s_w_ready[1]), .s1_w_bits_data(s_w_data[1]),
    .s1_w_bits_strb(s_w_strb[1]), .s1_w_bits_last(s_w_last[1]),
    .s1_b_valid(s_b_valid[1]), .s1_b_ready(s_b_ready[1]), .s1_b_bits_id(s_b_id[1]),
    .s1_b_bits_resp(s_b_resp[1]),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits_id(m_ar_id),
    .m_ar_bits_addr(m_ar_addr), .m_ar_bits_len(m_ar_len), .m_ar_bits_size(m_ar_size),
    .m_ar_bits_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits_id(m_r_id),
    .m_r_bits_data(m_r_data), .m_r_bits_resp(m_r_resp), .m_r_bits_last(m_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits_id(m_aw_id),
    .m_aw_bits_addr(m_aw_addr), .m_aw_bits_len(m_aw_len), .m_aw_bits_size(m_aw_size),
    .m_aw_bits_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits_data(m_w_data),
    .m_w_bits_strb(m_w_strb), .m_w_bits_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits_id(m_b_id),
    .m_b_bits_resp(m_b_resp),
    .o_rd_owner(rd_owner), .o_wr_owner(wr_owner)
  );

  // round-robin rule: a lone requester wins, a tie goes to the other port
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    return (v0 && v1) ? ~last : v1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      s_ar_valid[i] = 0; s_ar_id[i] = 0; s_ar_addr[i] = 0; s_ar_len[i] = 0;
      s_ar_size[i] = 0; s_ar_burst[i] = 0; s_r_ready[i] = 0;
      s_aw_valid[i] = 0; s_aw_id[i] = 0; s_aw_addr[i] = 0; s_aw_len[i] = 0;
      s_aw_size[i] = 0; s_aw_burst[i] = 0;
      s_w_valid[i] = 0; s_w_data[i] = 0; s_w_strb[i] = 0; s_w_last[i] = 0; s_b_ready[i] = 0;
    end
    m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0;
    m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0;
    m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    exp_rd_last = 1; exp_wr_last = 1;
  endtask

  task automatic start_ar(input int p, input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_ar_valid[p] = 1; s_ar_id[p] = id; s_ar_addr[p] = addr; s_ar_len[p] = len;
    s_ar_size[p] = 3'($urandom_range(0, 3)); s_ar_burst[p] = 2'($urandom_range(0, 2));
  endtask

  // Waits for the AR grant of port p (raised in idle this cycle) and completes it
  task automatic ar_phase(input int p);
    int cyc = 0;
    #1;
    while (m_ar_valid !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_checks++;
    if (cyc != 1) begin n_fail++; $display("FAIL ar_latency: got %0d cycles, want 1", cyc); end
    n_checks++;
    if (rd_owner !== p[0]) begin n_fail++; $display("FAIL rd_owner: got %b want %0d", rd_owner, p); end
    n_checks++;
    if ({m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst} !==
        {s_ar_id[p], s_ar_addr[p], s_ar_len[p], s_ar_size[p], s_ar_burst[p]}) begin
      n_fail++;
      $display("FAIL ar_payload: got id=%h addr=%h len=%h want id=%h addr=%h len=%h",
               m_ar_id, m_ar_addr, m_ar_len, s_ar_id[p], s_ar_addr[p], s_ar_len[p]);
    end
    m_ar_ready = 1;
    #1;
    n_checks++;
    if (s_ar_ready[p] !== 1'b1 || s_ar_ready[1-p] !== 1'b0) begin
      n_fail++; $display("FAIL ar_ready: got p=%b other=%b want 1/0", s_ar_ready[p], s_ar_ready[1-p]);
    end
    tick();
    s_ar_valid[0] = 0; s_ar_valid[1] = 0; m_ar_ready = 0;
  endtask

  // Downstream returns len+1 beats to port p; optional random stalls on both sides
  task automatic data_phase(input int p, input logic [5:0] id, input int len, input bit bp);
    logic [63:0] sent[$];
    logic [63:0] got[$];
    logic [63:0] cur;
    logic vld;
    int beat = 0, cyc = 0;
    bit done = 0;
    vld = 0;
    cur = {$urandom, $urandom};
    while (!done && cyc < 600) begin
      if (!vld) vld = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_r_valid = vld; m_r_id = id; m_r_data = cur; m_r_last = (beat == len);
      m_r_resp = 2'(beat);
      s_r_ready[p] = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      n_checks++;
      if (s_r_valid[p] !== m_r_valid || m_r_ready !== s_r_ready[p] || s_r_valid[1-p] !== 1'b0 || m_ar_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL r_route: got valid=%b ready=%b other=%b arv=%b want %b/%b/0/0",
                 s_r_valid[p], m_r_ready, s_r_valid[1-p], m_ar_valid, m_r_valid, s_r_ready[p]);
      end
      if (vld && s_r_ready[p]) begin
        got.push_back(s_r_data[p]);
        sent.push_back(cur);
        n_checks++;
        if (s_r_id[p] !== id || s_r_last[p] !== (beat == len) || s_r_resp[p] !== 2'(beat)) begin
          n_fail++;
          $display("FAIL r_beat%0d: got id=%h last=%b resp=%h want id=%h last=%b resp=%h",
                   beat, s_r_id[p], s_r_last[p], s_r_resp[p], id, (beat == len), 2'(beat));
        end
        if (beat == len) done = 1;
        beat++;
        vld = 0;
        cur = {$urandom, $urandom};
      end
      tick();
      cyc++;
    end
    m_r_valid = 0; m_r_last = 0; s_r_ready[p] = 0;
    n_checks++;
    if (!done || got.size() != len + 1) begin
      n_fail++; $display("FAIL r_count: got %0d beats want %0d", got.size(), len + 1);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== sent[i]) begin
        n_fail++; $display("FAIL r_data%0d: got %h want %h", i, got[i], sent[i]);
      end
    end
    $display("read  port=%0d id=%0d beats=%0d", p, id, got.size());
  endtask

  // Full write burst on port p; W presented w_early cycles before AW, B held b_hold cycles
  task automatic write_burst(input int p, input logic [5:0] id, input int len, input int w_early,
                             input int b_hold, input bit contend, input bit strb_ff, input logic [1:0] bresp);
    logic [63:0] wd[$];
    logic [7:0]  ws[$];
    int beat = 0, cyc = 0, sent = 0;
    bit done = 0;
    for (int i = 0; i <= len; i++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back(strb_ff ? 8'hFF : 8'($urandom));
    end
    s_w_valid[p] = 1; s_w_data[p] = wd[0]; s_w_strb[p] = ws[0]; s_w_last[p] = (len == 0);
    m_w_ready = 1;
    for (int i = 0; i < w_early; i++) begin
      #1;
      n_checks++;
      if (s_w_ready[p] !== 1'b0 || m_w_valid !== 1'b0) begin
        n_fail++; $display("FAIL w_early%0d: got ready=%b mvalid=%b want 0/0", i, s_w_ready[p], m_w_valid);
      end
      tick();
    end
    s_aw_valid[p] = 1; s_aw_id[p] = id; s_aw_addr[p] = $urandom; s_aw_len[p] = 8'(len);
    s_aw_size[p] = 3'd3; s_aw_burst[p] = 2'd1;
    if (contend) begin
      s_aw_valid[1-p] = 1; s_aw_id[1-p] = ~id; s_aw_addr[1-p] = $urandom; s_aw_len[1-p] = 8'(len + 1);
    end
    #1;
    while (m_aw_valid !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_checks++;
    if (cyc != 1 || wr_owner !== p[0]) begin
      n_fail++; $display("FAIL aw_grant: got cycles=%0d owner=%b want 1/%0d", cyc, wr_owner, p);
    end
    n_checks++;
    if ({m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst} !==
        {s_aw_id[p], s_aw_addr[p], s_aw_len[p], s_aw_size[p], s_aw_burst[p]}) begin
      n_fail++; $display("FAIL aw_payload: got id=%h addr=%h want id=%h addr=%h", m_aw_id, m_aw_addr, s_aw_id[p], s_aw_addr[p]);
    end
    m_aw_ready = 1;
    #1;
    n_checks++;
    if (s_aw_ready[p] !== 1'b1 || s_aw_ready[1-p] !== 1'b0 || s_w_ready[p] !== 1'b0 || m_w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL aw_hs: got awr=%b other=%b wready=%b mwv=%b want 1/0/0/0",
               s_aw_ready[p], s_aw_ready[1-p], s_w_ready[p], m_w_valid);
    end
    tick();
    s_aw_valid[0] = 0; s_aw_valid[1] = 0; m_aw_ready = 0;
    cyc = 0;
    while (!done && cyc < 400) begin
      s_w_data[p] = wd[beat]; s_w_strb[p] = ws[beat]; s_w_last[p] = (beat == len);
      m_w_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (m_w_valid !== 1'b1 || s_w_ready[p] !== m_w_ready || s_w_ready[1-p] !== 1'b0) begin
        n_fail++; $display("FAIL w_route: got mwv=%b wready=%b other=%b want 1/%b/0", m_w_valid, s_w_ready[p], s_w_ready[1-p], m_w_ready);
      end
      if (m_w_ready) begin
        n_checks++;
        if ({m_w_data, m_w_strb, m_w_last} !== {wd[beat], ws[beat], (beat == len)}) begin
          n_fail++; $display("FAIL w_beat%0d: got %h/%h/%b want %h/%h/%b", beat, m_w_data, m_w_strb, m_w_last, wd[beat], ws[beat], (beat == len));
        end
        sent++;
        if (beat == len) done = 1; else beat++;
      end
      tick();
      cyc++;
    end
    s_w_valid[p] = 0; m_w_ready = 0;
    n_checks++;
    if (sent != len + 1) begin n_fail++; $display("FAIL w_count: got %0d want %0d", sent, len + 1); end
    m_b_valid = 1; m_b_id = id; m_b_resp = bresp; s_b_ready[p] = 0;
    for (int i = 0; i < b_hold; i++) begin
      #1;
      n_checks++;
      if (s_b_valid[p] !== 1'b1 || m_b_ready !== 1'b0 || s_b_valid[1-p] !== 1'b0) begin
        n_fail++; $display("FAIL b_hold%0d: got bv=%b mbr=%b other=%b want 1/0/0", i, s_b_valid[p], m_b_ready, s_b_valid[1-p]);
      end
      tick();
    end
    s_b_ready[p] = 1;
    #1;
    n_checks++;
    if (s_b_valid[p] !== 1'b1 || m_b_ready !== 1'b1 || s_b_id[p] !== id || s_b_resp[p] !== bresp || s_b_valid[1-p] !== 1'b0) begin
      n_fail++;
      $display("FAIL b_route: got bv=%b mbr=%b id=%h resp=%h other=%b want 1/1/%h/%h/0",
               s_b_valid[p], m_b_ready, s_b_id[p], s_b_resp[p], s_b_valid[1-p], id, bresp);
    end
    tick();
    #1;
    n_checks++;
    if (s_b_valid[p] !== 1'b0 || m_b_ready !== 1'b0) begin
      n_fail++; $display("FAIL b_done: got bv=%b mbr=%b want 0/0", s_b_valid[p], m_b_ready);
    end
    m_b_valid = 0; s_b_ready[p] = 0;
    $display("write port=%0d id=%0d beats=%0d", p, id, sent);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    s_ar_valid[0] = 1; s_ar_addr[0] = 32'hDEAD_BEEF; s_aw_valid[1] = 1; s_aw_addr[1] = 32'h1234_5678;
    s_w_valid[1] = 1; m_r_valid = 1; m_b_valid = 1; m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
    s_r_ready[0] = 1; s_r_ready[1] = 1; s_b_ready[0] = 1; s_b_ready[1] = 1;
    tick(); tick(); tick();
    n_checks++;
    if ({m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready, rd_owner, wr_owner} !== 7'b0) begin
      n_fail++; $display("FAIL reset_m: got %b want 0000000", {m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready, rd_owner, wr_owner});
    end
    n_checks++;
    if ({s_ar_ready[0], s_ar_ready[1], s_aw_ready[0], s_aw_ready[1], s_w_ready[0], s_w_ready[1],
         s_r_valid[0], s_r_valid[1], s_b_valid[0], s_b_valid[1]} !== 10'b0) begin
      n_fail++; $display("FAIL reset_s: got nonzero valid/ready on master side, want all 0");
    end
    n_checks++;
    if ({m_ar_addr, m_aw_addr} !== 64'b0) begin
      n_fail++; $display("FAIL reset_payload: got ar=%h aw=%h want 0/0", m_ar_addr, m_aw_addr);
    end
    reset = 0;
    clear_inputs();
    exp_rd_last = 1; exp_wr_last = 1;
    tick();
  endtask

  task automatic test_single_read();
    logic wp;
    apply_reset();
    start_ar(0, 6'd3, 32'h8000_0000, 8'd3);
    wp = pick(1'b1, 1'b0, exp_rd_last); exp_rd_last = wp;
    ar_phase(int'(wp));
    data_phase(int'(wp), 6'd3, 3, 1'b0);
  endtask

  task automatic test_read_contention();
    logic wp;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      start_ar(0, 6'($urandom), $urandom, 8'd0);
      start_ar(1, 6'($urandom), $urandom, 8'd1);
      wp = pick(1'b1, 1'b1, exp_rd_last); exp_rd_last = wp;
      n_checks++;
      if (int'(wp) != (r % 2)) begin n_fail++; $display("FAIL model_rr%0d: got %0d want %0d", r, wp, r % 2); end
      ar_phase(int'(wp));
      data_phase(int'(wp), s_ar_id[wp], int'(s_ar_len[wp]), 1'b0);
    end
  endtask

  task automatic test_random_reads();
    logic v0, v1, wp;
    for (int r = 0; r < 8; r++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      if (v0) start_ar(0, 6'($urandom), $urandom, 8'($urandom_range(0, 3)));
      if (v1) start_ar(1, 6'($urandom), $urandom, 8'($urandom_range(0, 3)));
      wp = pick(v0, v1, exp_rd_last); exp_rd_last = wp;
      ar_phase(int'(wp));
      data_phase(int'(wp), s_ar_id[wp], int'(s_ar_len[wp]), 1'($urandom));
    end
  endtask

  task automatic test_backpressure();
    logic wp;
    start_ar(1, 6'h2A, 32'h0010_0000, 8'd15);
    wp = pick(1'b0, 1'b1, exp_rd_last); exp_rd_last = wp;
    ar_phase(int'(wp));
    data_phase(int'(wp), 6'h2A, 15, 1'b1);
  endtask

  task automatic test_concurrent();
    apply_reset();
    fork
      begin
        start_ar(0, 6'h11, 32'h8000_1000, 8'd7);
        exp_rd_last = pick(1'b1, 1'b0, exp_rd_last);
        ar_phase(0);
        data_phase(0, 6'h11, 7, 1'b0);
      end
      begin
        exp_wr_last = pick(1'b0, 1'b1, exp_wr_last);
        write_burst(1, 6'h22, 1, 0, 1, 1'b0, 1'b1, 2'b00);
      end
    join
  endtask

  task automatic test_write_ordering();
    apply_reset();
    exp_wr_last = pick(1'b0, 1'b1, exp_wr_last);
    write_burst(1, 6'h05, 2, 2, 5, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_write_contention();
    logic wp;
    for (int r = 0; r < 4; r++) begin
      wp = pick(1'b1, 1'b1, exp_wr_last); exp_wr_last = wp;
      write_burst(int'(wp), 6'($urandom), $urandom_range(0, 3), 0, $urandom_range(0, 2),
                  1'b1, 1'b0, 2'($urandom));
    end
  endtask

  task automatic test_reset_mid_burst();
    logic wp;
    apply_reset();
    start_ar(0, 6'h07, 32'h8000_2000, 8'd7);
    exp_rd_last = pick(1'b1, 1'b0, exp_rd_last);
    ar_phase(0);
    m_r_valid = 1; m_r_id = 6'h07; s_r_ready[0] = 1;
    for (int i = 0; i < 2; i++) begin
      m_r_data = {$urandom, $urandom};
      #1;
      n_checks++;
      if (s_r_valid[0] !== 1'b1 || s_r_data[0] !== m_r_data) begin
        n_fail++; $display("FAIL rst_beat%0d: got v=%b d=%h want 1/%h", i, s_r_valid[0], s_r_data[0], m_r_data);
      end
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    exp_rd_last = 1; exp_wr_last = 1;
    #1;
    n_checks++;
    if ({s_r_valid[0], s_r_valid[1], m_r_ready, m_ar_valid, s_ar_ready[0], s_ar_ready[1], rd_owner, wr_owner} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got rv0=%b mrr=%b arv=%b owner=%b want all 0", s_r_valid[0], m_r_ready, m_ar_valid, rd_owner);
    end
    clear_inputs();
    start_ar(1, 6'h09, 32'h8000_3000, 8'd0);
    wp = pick(1'b0, 1'b1, exp_rd_last); exp_rd_last = wp;
    ar_phase(int'(wp));
    data_phase(int'(wp), 6'h09, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_contention();
    test_random_reads();
    test_backpressure();
    test_concurrent();
    test_write_ordering();
    test_write_contention();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
